axi_write_arbiter: RTL

Two-requester AXI4 write-channel arbiter in front of the single memory-mapped AXI4 slave. It grants one master's complete write transaction (AW, W burst, B) to the slave, switching only at transaction boundaries. Arbitration is round-robin. It regenerates WLAST from AWLEN and flags any mismatch in a master's WLAST. It sits between the bus requesters and the slave's write port; the read channel bypasses it.

---
 rtl/axi_write_arbiter_pkg.sv | 14 +
 rtl/axi_write_arbiter_rr.sv | 20 ++
 rtl/axi_write_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/axi_write_arbiter_pkg.sv
// Shared types and constants for the two-master AXI4 write-channel arbiter.
package axi_write_arbiter_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int BURST_LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_e;

endpackage

// File: rtl/axi_write_arbiter_rr.sv
// Two-way round-robin pick: on a tie the master that did not win last time goes next.
module rr_arbiter2
    import axi_write_arbiter_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   last_grant,
    output logic                   winner,
    output logic                   any_req
);

    always_comb begin
        any_req = |req;
        if (&req) begin
            winner = ~last_grant;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/axi_write_arbiter.sv
// Two-master AXI4 write arbiter: one whole AW/W/B transaction at a time, round-robin,
// with WLAST regenerated from AWLEN and a sticky flag for masters sending a wrong WLAST.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending AWVALIDs
// ADDR  | granted master's AW forwarded to the slave
// DATA  | granted master's W beats forwarded, WLAST from the beat counter
// RESP  | slave's B routed back to the granted master
module axi_write_arbiter
    import axi_write_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  ARESTN,

    input  logic [ADDR_WIDTH-1:0] m0_AWADDR,
    input  logic [7:0]            m0_AWLEN,
    input  logic [2:0]            m0_AWSIZE,
    input  logic                  m0_AWVALID,
    output logic                  m0_AWREADY,
    input  logic [DATA_WIDTH-1:0] m0_WDATA,
    input  logic                  m0_WLAST,
    input  logic                  m0_WVALID,
    output logic                  m0_WREADY,
    output logic [1:0]            m0_BRESP,
    output logic                  m0_BVALID,
    input  logic                  m0_BREADY,

    input  logic [ADDR_WIDTH-1:0] m1_AWADDR,
    input  logic [7:0]            m1_AWLEN,
    input  logic [2:0]            m1_AWSIZE,
    input  logic                  m1_AWVALID,
    output logic                  m1_AWREADY,
    input  logic [DATA_WIDTH-1:0] m1_WDATA,
    input  logic                  m1_WLAST,
    input  logic                  m1_WVALID,
    output logic                  m1_WREADY,
    output logic [1:0]            m1_BRESP,
    output logic                  m1_BVALID,
    input  logic                  m1_BREADY,

    output logic [ADDR_WIDTH-1:0] s_AWADDR,
    output logic [7:0]            s_AWLEN,
    output logic [2:0]            s_AWSIZE,
    output logic                  s_AWVALID,
    input  logic                  s_AWREADY,
    output logic [DATA_WIDTH-1:0] s_WDATA,
    output logic                  s_WLAST,
    output logic                  s_WVALID,
    input  logic                  s_WREADY,
    input  logic [1:0]            s_BRESP,
    input  logic                  s_BVALID,
    output logic                  s_BREADY,

    output logic                  grant,
    output logic                  busy,
    output logic                  wlast_err
);

    arb_state_e             state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic [BURST_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [BURST_LEN_W-1:0] len_q, len_d;
    logic                   wlast_err_q, wlast_err_d;

    logic                   winner, any_req;
    logic [ADDR_WIDTH-1:0]  sel_awaddr;
    logic [7:0]             sel_awlen;
    logic [2:0]             sel_awsize;
    logic                   sel_awvalid;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   sel_wlast, sel_wvalid, sel_bready;
    logic                   aw_hs, w_hs, b_hs, last_beat;

    rr_arbiter2 u_rr (
        .req        ({m1_AWVALID, m0_AWVALID}),
        .last_grant (last_grant_q),
        .winner     (winner),
        .any_req    (any_req)
    );

    always_comb begin
        sel_awaddr  = grant_q ? m1_AWADDR  : m0_AWADDR;
        sel_awlen   = grant_q ? m1_AWLEN   : m0_AWLEN;
        sel_awsize  = grant_q ? m1_AWSIZE  : m0_AWSIZE;
        sel_awvalid = grant_q ? m1_AWVALID : m0_AWVALID;
        sel_wdata   = grant_q ? m1_WDATA   : m0_WDATA;
        sel_wlast   = grant_q ? m1_WLAST   : m0_WLAST;
        sel_wvalid  = grant_q ? m1_WVALID  : m0_WVALID;
        sel_bready  = grant_q ? m1_BREADY  : m0_BREADY;

        aw_hs     = (state_q == ADDR) && sel_awvalid && s_AWREADY;
        w_hs      = (state_q == DATA) && sel_wvalid && s_WREADY;
        b_hs      = (state_q == RESP) && s_BVALID && sel_bready;
        last_beat = (beat_cnt_q == len_q);
    end

    always_ff @(posedge clk or negedge ARESTN) begin
        if (!ARESTN) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            len_q        <= '0;
            wlast_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
            wlast_err_q  <= wlast_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ADDR;
            ADDR:    if (aw_hs) state_d = DATA;
            DATA:    if (w_hs && last_beat) state_d = RESP;
            RESP:    if (b_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The counter stops at len_q on the final beat, so it never wraps.
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        len_d        = len_q;
        wlast_err_d  = wlast_err_q;
        if ((state_q == IDLE) && any_req) grant_d = winner;
        if (aw_hs) begin
            len_d      = sel_awlen;
            beat_cnt_d = '0;
        end
        if (w_hs) begin
            if (!last_beat) beat_cnt_d = beat_cnt_q + 8'd1;
            if (sel_wlast != last_beat) wlast_err_d = 1'b1;
        end
        if (b_hs) last_grant_d = grant_q;
    end

    always_comb begin
        m0_AWREADY = 1'b0;
        m1_AWREADY = 1'b0;
        m0_WREADY  = 1'b0;
        m1_WREADY  = 1'b0;
        m0_BVALID  = 1'b0;
        m1_BVALID  = 1'b0;
        m0_BRESP   = 2'b00;
        m1_BRESP   = 2'b00;
        s_AWADDR   = '0;
        s_AWLEN    = '0;
        s_AWSIZE   = '0;
        s_AWVALID  = 1'b0;
        s_WDATA    = '0;
        s_WLAST    = 1'b0;
        s_WVALID   = 1'b0;
        s_BREADY   = 1'b0;
        case (state_q)
            ADDR: begin
                s_AWADDR  = sel_awaddr;
                s_AWLEN   = sel_awlen;
                s_AWSIZE  = sel_awsize;
                s_AWVALID = sel_awvalid;
                if (grant_q) m1_AWREADY = s_AWREADY;
                else         m0_AWREADY = s_AWREADY;
            end
            DATA: begin
                s_WDATA  = sel_wdata;
                s_WVALID = sel_wvalid;
                s_WLAST  = last_beat;
                if (grant_q) m1_WREADY = s_WREADY;
                else         m0_WREADY = s_WREADY;
            end
            RESP: begin
                s_BREADY = sel_bready;
                if (grant_q) begin
                    m1_BVALID = s_BVALID;
                    m1_BRESP  = s_BRESP;
                end else begin
                    m0_BVALID = s_BVALID;
                    m0_BRESP  = s_BRESP;
                end
            end
            default: ;
        endcase
        busy      = (state_q != IDLE);
        grant     = grant_q;
        wlast_err = wlast_err_q;
    end

endmodule
